// File: rtl/rsa_pkg.sv
// rsa_pkg: shared op codes and FSM encoding for the RSA exponent sequencer and modmul
package rsa_pkg;
  localparam int RSA_WIDTH = 1024;
  localparam int RSA_CNT_W = 11;
  localparam logic [1:0] OP_INIT = 2'b00;
  localparam logic [1:0] OP_SQR  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_ONE  = 2'b11;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/rsa_exp_sequencer_if.sv
// rsa_exp_sequencer_if: start/exponent handshake and modmul op channel
interface rsa_exp_sequencer_if #(parameter int WIDTH = 1024, parameter int CNT_W = 11);
  logic             iStart;
  logic [WIDTH-1:0] iE;
  logic [CNT_W-1:0] iNumBit;
  logic             oOpStart;
  logic [1:0]       oOp;
  logic [CNT_W-1:0] oBitIdx;
  logic             iOpDone;
  logic             oBusy;
  logic             oDone;
  logic             oErr;
  modport master (output iStart, iE, iNumBit, iOpDone,
                  input  oOpStart, oOp, oBitIdx, oBusy, oDone, oErr);
  modport slave  (input  iStart, iE, iNumBit, iOpDone,
                  output oOpStart, oOp, oBitIdx, oBusy, oDone, oErr);
endinterface

// File: rtl/rsa_exp_sequencer.sv
// rsa_exp_sequencer: left-to-right square-and-multiply op sequencer for modular exponentiation
module rsa_exp_sequencer
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int CNT_W = RSA_CNT_W
) (
  input logic                 iClk,
  input logic                 iRst,
  rsa_exp_sequencer_if.slave  bus
);
  localparam int IW = $clog2(WIDTH);
  state_t           state, state_n;
  logic [WIDTH-1:0] e_reg, e_n;
  logic [1:0]       op, op_n;
  logic [CNT_W-1:0] idx, idx_n, n_clamp;
  logic             err, err_n, mul_next, fin;
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) state <= IDLE;
    else      state <= state_n;
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      e_reg <= '0;
      op    <= '0;
      idx   <= '0;
      err   <= 1'b0;
    end else begin
      e_reg <= e_n;
      op    <= op_n;
      idx   <= idx_n;
      err   <= err_n;
    end
  // a set bit after a square adds a multiply at the same index; idx==0 never decrements
  always_comb begin
    n_clamp  = bus.iNumBit > CNT_W'(WIDTH) ? CNT_W'(WIDTH) : bus.iNumBit;
    mul_next = op == OP_SQR && e_reg[idx[IW-1:0]];
    fin      = !mul_next && idx == '0;
    state_n  = state;
    e_n      = e_reg;
    op_n     = op;
    idx_n    = idx;
    err_n    = err;
    case (state)
      IDLE: if (bus.iStart) begin
        state_n = ISSUE;
        e_n     = bus.iE;
        err_n   = bus.iNumBit > CNT_W'(WIDTH);
        op_n    = n_clamp == '0 ? OP_ONE : OP_INIT;
        idx_n   = n_clamp == '0 ? '0 : n_clamp - CNT_W'(1);
      end
      ISSUE: state_n = WAIT;
      WAIT: if (bus.iOpDone) begin
        state_n = fin ? DONE : ISSUE;
        op_n    = fin ? op : (mul_next ? OP_MUL : OP_SQR);
        idx_n   = fin || mul_next ? idx : idx - CNT_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.oOpStart = state == ISSUE;
  assign bus.oBusy    = state != IDLE;
  assign bus.oDone    = state == DONE;
  assign bus.oOp      = op;
  assign bus.oBitIdx  = idx;
  assign bus.oErr     = err;
endmodule
